// File: rtl/music_sequencer.sv
// music_sequencer
//   Plays a melody stored in the music note ROM. It steps through ROM
//   addresses, holds each note for TICKS_PER_NOTE cycles and presents the
//   current note code to the tone generator. It supports play/pause, stop,
//   end-of-song detection (last address or a zero terminator) and optional
//   looping.
//
//   Optional build macro: MUSIC_GAP_EN
//     When defined, note_valid_o goes low for the last GAP_TICKS cycles of
//     every note, and stays low through the following fetch. Repeated
//     identical notes are then heard as separate notes. Timing is unchanged.
//
//   Ports
//     clk_i        system clock
//     reset_i      asynchronous, active-high reset
//     play_i       level: 1 = run, 0 = pause
//     stop_i       pulse: abort playback and rewind to address 0
//     loop_en_i    1 = restart at address 0 after the last note
//     rom_addr_o   registered ROM address
//     rom_note_i   ROM data, valid the cycle after rom_addr_o is sampled
//     note_o       current note code
//     note_valid_o 1 = tone generator sounds note_o
//     playing_o    1 in any state other than IDLE and DONE
//     song_done_o  one-cycle pulse when the song ends without looping
module music_sequencer #(
    parameter int TICKS_PER_NOTE = 12500000,
    parameter int SONG_LEN       = 32,
    parameter int GAP_TICKS      = 1250000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       play_i,
    input  logic       stop_i,
    input  logic       loop_en_i,
    output logic [7:0] rom_addr_o,
    input  logic [7:0] rom_note_i,
    output logic [7:0] note_o,
    output logic       note_valid_o,
    output logic       playing_o,
    output logic       song_done_o
);

    localparam int CW = $clog2(TICKS_PER_NOTE);
    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_NOTE - 1);
    localparam logic [7:0]    LAST_ADDR = 8'(SONG_LEN - 1);
    localparam int            GAP_START = TICKS_PER_NOTE - GAP_TICKS;
`ifdef MUSIC_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    note_q, note_d;
    logic          nv_q, nv_d;       // note sounding, before pause/gap masking
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          armed_q, armed_d; // DONE has seen play low; a high now restarts
    logic          end_song;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            note_q  <= 8'd0;
            nv_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            nv_q    <= nv_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        nv_d     = nv_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        armed_d  = armed_q;
        end_song = 1'b0;

        if (stop_i) begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
            note_d  = 8'd0;
            nv_d    = 1'b0;
            cnt_d   = '0;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = 8'd0;
                    if (play_i) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    // A zero code marks the end of the programmed song.
                    if (rom_note_i == 8'd0) begin
                        end_song = 1'b1;
                    end else begin
                        note_d  = rom_note_i;
                        nv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Pause simply freezes the counter here.
                    if (play_i) begin
                        if (cnt_q == LAST_TICK) begin
                            // With the gap, silence lasts through the fetch.
                            if (GAP_EN) nv_d = 1'b0;
                            if (addr_q == LAST_ADDR) begin
                                end_song = 1'b1;
                            end else begin
                                addr_d  = addr_q + 8'd1;
                                state_d = S_FETCH;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!play_i) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        addr_d  = 8'd0;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (end_song) begin
                if (loop_en_i) begin
                    addr_d  = 8'd0;
                    state_d = S_FETCH;
                end else begin
                    note_d  = 8'd0;
                    nv_d    = 1'b0;
                    done_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_DONE;
                end
            end
        end
    end

    // Pause and gap silence the tone without disturbing the held note code.
    always_comb begin
        note_valid_o = nv_q;
        if (state_q == S_HOLD) begin
            if (!play_i) note_valid_o = 1'b0;
            if (GAP_EN && (int'(cnt_q) >= GAP_START)) note_valid_o = 1'b0;
        end
    end

    assign rom_addr_o  = addr_q;
    assign note_o      = note_q;
    assign playing_o   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign song_done_o = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer. A reference model expands a song, its pause
// schedule and the loop setting into a per-cycle list of play input and
// expected outputs. That list is then replayed against the DUT. Directed
// steps cover stop, asynchronous reset and the DONE restart handshake.
module tb_music_sequencer;

    localparam int T  = 4;
    localparam int SL = 4;
    localparam int G  = 1;
`ifdef MUSIC_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1, play = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [7:0] rom_addr, rom_note, note;
    logic       note_valid, playing, song_done;
    logic [7:0] rom [256];
    int         tests = 0, fails = 0;

    typedef struct {
        logic       play;
        logic [7:0] addr;
        logic [7:0] note;
        logic       nv;
        logic       pl;
        logic       dn;
    } cyc_t;
    cyc_t exp_q[$];

    music_sequencer #(.TICKS_PER_NOTE(T), .SONG_LEN(SL), .GAP_TICKS(G)) dut (
        .clk_i(clk), .reset_i(reset), .play_i(play), .stop_i(stop),
        .loop_en_i(loop_en), .rom_addr_o(rom_addr), .rom_note_i(rom_note),
        .note_o(note), .note_valid_o(note_valid), .playing_o(playing),
        .song_done_o(song_done)
    );

    always #5 clk = ~clk;

    // Registered-read ROM.
    always @(posedge clk) rom_note <= rom[rom_addr];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void emit(input logic p, input logic [7:0] a, input logic [7:0] n,
                                 input logic nv, input logic pl, input logic dn);
        cyc_t c;
        c.play = p; c.addr = a; c.note = n; c.nv = nv; c.pl = pl; c.dn = dn;
        exp_q.push_back(c);
    endfunction

    // Expand the song into cycles, starting with the IDLE cycle in which play rises.
    // Optionally insert a directed pause of pl cycles before hold tick pt of note pj.
    // Random pauses and random play during fetch cycles can also be enabled.
    function automatic void build(input bit lp, input int pj, input int pt, input int pl,
                                  input bit rnd, input int maxc);
        int         a = 0, idx = 0, np;
        logic [7:0] n = 8'd0;
        logic       snd = 1'b0, eos;
        emit(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() < maxc) begin
            for (int f = 0; f < 2; f++)
                emit(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 8'(a), n, GAP ? 1'b0 : snd, 1'b1, 1'b0);
            eos = 1'b0;
            if (rom[a] == 8'd0) begin
                eos = 1'b1;
            end else begin
                n = rom[a];
                snd = 1'b1;
                for (int t = 0; t < T; t++) begin
                    np = (idx == pj && t == pt) ? pl :
                         ((rnd && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
                    repeat (np) emit(1'b0, 8'(a), n, 1'b0, 1'b1, 1'b0);
                    emit(1'b1, 8'(a), n, GAP ? (t < T - G) : 1'b1, 1'b1, 1'b0);
                end
                idx++;
                if (a == SL - 1) eos = 1'b1;
                else a++;
            end
            if (eos) begin
                if (lp) begin
                    a = 0;
                end else begin
                    emit(1'b1, 8'(a), 8'd0, 1'b0, 1'b0, 1'b1);
                    repeat (3) emit(1'b1, 8'(a), 8'd0, 1'b0, 1'b0, 1'b0);
                    break;
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1; play = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        chk("rst.addr", rom_addr, 8'd0);
        chk("rst.note", note, 8'd0);
        chk("rst.nv", {7'd0, note_valid}, 8'd0);
        chk("rst.playing", {7'd0, playing}, 8'd0);
        chk("rst.done", {7'd0, song_done}, 8'd0);
        reset = 1'b0;
    endtask

    task automatic replay(input string tag);
        cyc_t c;
        int   i = 0;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            play = c.play;
            @(negedge clk);
            chk($sformatf("%s[%0d].addr", tag, i), rom_addr, c.addr);
            chk($sformatf("%s[%0d].note", tag, i), note, c.note);
            chk($sformatf("%s[%0d].nv", tag, i), {7'd0, note_valid}, {7'd0, c.nv});
            chk($sformatf("%s[%0d].playing", tag, i), {7'd0, playing}, {7'd0, c.pl});
            chk($sformatf("%s[%0d].done", tag, i), {7'd0, song_done}, {7'd0, c.dn});
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic load_default();
        for (int k = 0; k < 256; k++) rom[k] = 8'd0;
        rom[0] = 8'd27; rom[1] = 8'd26; rom[2] = 8'd27; rom[3] = 8'd28;
    endtask

    initial begin
        bit found;
        int tp;
        load_default();

        // Plain song, no loop.
        do_reset(); loop_en = 1'b0;
        build(1'b0, -1, 0, 0, 1'b0, 200); replay("song");

        // Terminator at entry 2.
        rom[2] = 8'd0;
        do_reset(); build(1'b0, -1, 0, 0, 1'b0, 200); replay("term");
        load_default();

        // Looping for 40 cycles.
        do_reset(); loop_en = 1'b1;
        build(1'b1, -1, 0, 0, 1'b0, 40); replay("loop");
        loop_en = 1'b0;

        // 10-cycle pause with the counter at 2 during note 26.
        do_reset(); build(1'b0, 1, 2, 10, 1'b0, 200); replay("pause");

        // Stop during the hold of note 27 at address 2, with play still high.
        do_reset(); play = 1'b1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (rom_addr == 8'd2 && note == 8'd27) found = 1'b1;
        end
        chk("stop.reach", {7'd0, found}, 8'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("stop.addr", rom_addr, 8'd0);
        chk("stop.note", note, 8'd0);
        chk("stop.nv", {7'd0, note_valid}, 8'd0);
        chk("stop.playing", {7'd0, playing}, 8'd0);
        chk("stop.done", {7'd0, song_done}, 8'd0);
        @(posedge clk); #1;
        chk("stop.refetch", {7'd0, playing}, 8'd1);
        chk("stop.done2", {7'd0, song_done}, 8'd0);

        // Asynchronous reset in the middle of a note.
        do_reset(); play = 1'b1; found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (note_valid) found = 1'b1;
        end
        chk("arst.reach", {7'd0, found}, 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst.addr", rom_addr, 8'd0);
        chk("arst.note", note, 8'd0);
        chk("arst.nv", {7'd0, note_valid}, 8'd0);
        chk("arst.playing", {7'd0, playing}, 8'd0);

        // DONE needs a low-then-high on play to restart.
        do_reset(); play = 1'b1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (song_done) found = 1'b1;
        end
        chk("done.reach", {7'd0, found}, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done.hold", {7'd0, playing}, 8'd0);
        end
        play = 1'b0;
        @(negedge clk);
        play = 1'b1;
        @(negedge clk);
        chk("done.restart", {7'd0, playing}, 8'd1);
        chk("done.addr", rom_addr, 8'd0);
        @(negedge clk); @(negedge clk);
        chk("done.note", note, 8'd27);
        chk("done.nv", {7'd0, note_valid}, 8'd1);

        // Random songs, pauses and loop settings.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < SL; k++) rom[k] = 8'($urandom_range(1, 255));
            tp = $urandom_range(0, 4);
            if (tp >= 1 && tp <= 3) rom[tp] = 8'd0;
            loop_en = 1'($urandom_range(0, 1));
            do_reset();
            build(loop_en, -1, 0, 0, 1'b1, 60);
            replay($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
